// File: rtl/ptr_word_asm.sv
// Paper-tape reader word assembler. Alpha frames go straight into the buffer.
// Binary frames are packed six at a time into a 36-bit word.
module ptr_word_asm (
  input  logic         clk,
  input  logic         reset,
  input  logic         frame_valid,
  input  logic [1:8]   frame_data,
  input  logic         cono_strobe,
  input  logic [18:35] cono_data,
  input  logic         datai_strobe,
  output logic [0:35]  datai_data,
  output logic [18:35] coni_data,
  output logic [1:7]   pi_req,
  output logic         motor_on
);

  logic [0:35] buffer_q, buffer_d;
  logic [0:35] shift_q, shift_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        binary_q, binary_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [2:0]  pia_q, pia_d;

  logic        accept;
  logic [0:35] word_next;
  logic        unused_bits;

  assign unused_bits = ^{cono_data[18:29], shift_q[0:5]};

  // CONO has priority over DATAI; either one blocks a frame in the same cycle.
  assign accept    = frame_valid & busy_q & ~cono_strobe & ~datai_strobe;
  assign word_next = {shift_q[6:35], frame_data[3:8]};

  always_comb begin
    buffer_d = buffer_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    binary_d = binary_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pia_d    = pia_q;
    if (cono_strobe) begin
      binary_d = cono_data[30];
      busy_d   = cono_data[31];
      done_d   = cono_data[32];
      pia_d    = cono_data[33:35];
      shift_d  = '0;
      cnt_d    = '0;
    end else if (datai_strobe) begin
      done_d  = 1'b0;
      busy_d  = 1'b1;
      shift_d = '0;
      cnt_d   = '0;
    end else if (accept) begin
      if (!binary_q) begin
        buffer_d = {28'b0, frame_data};
        done_d   = 1'b1;
        busy_d   = 1'b0;
      end else if (frame_data[8]) begin
        shift_d = word_next;
        // The sixth frame completes the word on the same edge, so cnt never rests at 6.
        if (cnt_q == 3'd5) begin
          buffer_d = word_next;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buffer_q <= '0;
      shift_q  <= '0;
      cnt_q    <= '0;
      binary_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pia_q    <= '0;
    end else begin
      buffer_q <= buffer_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      binary_q <= binary_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pia_q    <= pia_d;
    end
  end

  always_comb begin
    pi_req = '0;
    for (int n = 1; n <= 7; n++) pi_req[n] = done_q && (pia_q == 3'(n));
  end

  assign datai_data = buffer_q;
  assign coni_data  = {12'b0, binary_q, busy_q, done_q, pia_q};
  assign motor_on   = busy_q;

endmodule

// File: tb/tb_ptr_word_asm.sv
// Directed bench for ptr_word_asm; completed words are queued as stimulus is sent
// and popped when the reader reports done.
module tb_ptr_word_asm;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         frame_valid = 1'b0;
  logic [1:8]   frame_data = '0;
  logic         cono_strobe = 1'b0;
  logic [18:35] cono_data = '0;
  logic         datai_strobe = 1'b0;
  logic [0:35]  datai_data;
  logic [18:35] coni_data;
  logic [1:7]   pi_req;
  logic         motor_on;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [35:0] exp_q[$];

  ptr_word_asm dut (
    .clk(clk), .reset(reset), .frame_valid(frame_valid), .frame_data(frame_data),
    .cono_strobe(cono_strobe), .cono_data(cono_data), .datai_strobe(datai_strobe),
    .datai_data(datai_data), .coni_data(coni_data), .pi_req(pi_req), .motor_on(motor_on)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0o expected=%0o", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cono(input logic [17:0] v);
    cono_data = v;
    cono_strobe = 1'b1;
    tick();
    cono_strobe = 1'b0;
  endtask

  task automatic frame(input logic [7:0] f);
    frame_data = f;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
  endtask

  // Binary frame: hole 1 set as noise, holes 3..8 carry the data.
  task automatic bframe(input logic [5:0] d);
    frame({2'b10, d});
  endtask

  task automatic expect_word(input string tag);
    logic [35:0] exp;
    int n = 0;
    while (!coni_data[32] && n < 4) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, 64'(coni_data[32]), 64'd1);
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 64'd0, 64'd1);
    end else begin
      exp = exp_q.pop_front();
      chk({tag, "_buffer"}, 64'(datai_data), 64'(exp));
    end
  endtask

  logic [5:0] wd [6];

  initial begin
    wd[0] = 6'o11; wd[1] = 6'o77; wd[2] = 6'o73;
    wd[3] = 6'o23; wd[4] = 6'o27; wd[5] = 6'o67;

    // Reset state
    tick(); tick();
    chk("rst_datai", 64'(datai_data), 64'd0);
    chk("rst_coni", 64'(coni_data), 64'd0);
    chk("rst_pi", 64'(pi_req), 64'd0);
    chk("rst_motor", 64'(motor_on), 64'd0);
    reset = 1'b0;
    tick();

    // Alpha read: busy, PIA=3
    cono(18'o000023);
    chk("alpha_coni", 64'(coni_data), 64'o23);
    chk("alpha_motor", 64'(motor_on), 64'd1);
    exp_q.push_back(36'o215);
    frame(8'o215);
    expect_word("alpha");
    chk("alpha_busy", 64'(coni_data[31]), 64'd0);
    chk("alpha_pi", 64'(pi_req), 64'(7'b0010000));

    // Binary word: binary, busy, PIA=4
    cono(18'o000064);
    exp_q.push_back(36'o117773232767);
    for (int i = 0; i < 5; i++) bframe(wd[i]);
    chk("bin_not_early_done", 64'(coni_data[32]), 64'd0);
    chk("bin_not_early_pi", 64'(pi_req), 64'd0);
    chk("bin_cnt5", 64'(dut.cnt_q), 64'd5);
    bframe(wd[5]);
    expect_word("bin");
    chk("bin_pi", 64'(pi_req), 64'(7'b0001000));
    chk("bin_cnt_clr", 64'(dut.cnt_q), 64'd0);

    // Same word with a hole-8-clear frame after the third
    cono(18'o000064);
    exp_q.push_back(36'o117773232767);
    for (int i = 0; i < 3; i++) bframe(wd[i]);
    frame(8'o076);
    chk("skip_cnt", 64'(dut.cnt_q), 64'd3);
    chk("skip_shift", 64'(dut.shift_q), 64'o117773);
    for (int i = 3; i < 6; i++) bframe(wd[i]);
    expect_word("skip");

    // DATAI handoff: pre-edge buffer visible during the strobe cycle
    datai_strobe = 1'b1;
    #1;
    chk("datai_word", 64'(datai_data), 64'o117773232767);
    tick();
    datai_strobe = 1'b0;
    chk("datai_done", 64'(coni_data[32]), 64'd0);
    chk("datai_busy", 64'(coni_data[31]), 64'd1);
    chk("datai_pi", 64'(pi_req), 64'd0);
    chk("datai_cnt", 64'(dut.cnt_q), 64'd0);

    // Abort mid-word with a CONO that clears busy
    cono(18'o000064);
    for (int i = 0; i < 3; i++) bframe(wd[i]);
    cono(18'o000004);
    chk("abort_busy", 64'(coni_data[31]), 64'd0);
    for (int i = 3; i < 6; i++) bframe(wd[i]);
    chk("abort_cnt", 64'(dut.cnt_q), 64'd0);
    chk("abort_shift", 64'(dut.shift_q), 64'd0);
    chk("abort_buffer", 64'(datai_data), 64'o117773232767);
    chk("abort_done", 64'(coni_data[32]), 64'd0);

    // CONO and DATAI together: CONO (busy+done, PIA=5) wins
    cono_data = 18'o000035;
    cono_strobe = 1'b1;
    datai_strobe = 1'b1;
    tick();
    cono_strobe = 1'b0;
    datai_strobe = 1'b0;
    chk("conflict_coni", 64'(coni_data), 64'o35);
    chk("conflict_pi", 64'(pi_req), 64'(7'b0000100));
    exp_q.push_back(36'o101);
    frame(8'o101);
    expect_word("conflict_alpha");
    chk("conflict_busy", 64'(coni_data[31]), 64'd0);

    // Frame coinciding with CONO is dropped
    cono(18'o000064);
    bframe(wd[0]);
    cono_data = 18'o000064;
    cono_strobe = 1'b1;
    frame_data = {2'b00, wd[1]};
    frame_valid = 1'b1;
    tick();
    cono_strobe = 1'b0;
    frame_valid = 1'b0;
    chk("cono_frame_cnt", 64'(dut.cnt_q), 64'd0);

    // Reset mid-word, asserted between edges
    bframe(wd[0]);
    bframe(wd[1]);
    #3;
    reset = 1'b1;
    #1;
    chk("midrst_datai", 64'(datai_data), 64'd0);
    chk("midrst_coni", 64'(coni_data), 64'd0);
    chk("midrst_pi", 64'(pi_req), 64'd0);
    chk("midrst_motor", 64'(motor_on), 64'd0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) bframe(wd[i]);
    frame(8'o215);
    chk("postrst_coni", 64'(coni_data), 64'd0);
    chk("postrst_buffer", 64'(datai_data), 64'd0);
    cono(18'o000023);
    exp_q.push_back(36'o377);
    frame(8'o377);
    expect_word("postrst_alpha");
    chk("postrst_pi", 64'(pi_req), 64'(7'b0010000));
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
